filtez_zero_predictor: RTL and testbench

// - Zero-section predictor read side of the ADPCM coder. It is the reader of the bli/dlti arrays that upzero writes.
// - Computes ap_return = (sum over i=0..NTAPS-1 of bli[i]*dlti[i]) >>> SHIFT.
// - Sits beside upzero under the same ap_ctrl_hs block-level handshake.
// - Each run issues one read per tap to the bli and dlti memories, then presents a 32-bit result.

---
 rtl/adpcm_pkg.sv | 20 ++
 rtl/zero_mac.sv | 52 +++++
 rtl/filtez_zero_predictor.sv | 115 +++++++++++
 tb/tb_filtez_zero_predictor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/adpcm_pkg.sv
// Shared ADPCM definitions used by the zero-section predictor.
//   NTAPS_Z : default number of zero-section taps
//   ZSHIFT  : arithmetic right shift applied to the zero-section sum
//   state_t : block-level FSM states
//   acc_t   : signed 64-bit accumulator type
package adpcm_pkg;

  localparam int NTAPS_Z = 6;
  localparam int ZSHIFT  = 14;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef logic signed [63:0] acc_t;

endpackage

// File: rtl/zero_mac.sv
// Multiply-accumulate unit for the zero-section predictor.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   clear     : zero the accumulator (priority over enable)
//   enable    : add a*b into the accumulator
//   a, b      : signed DW-bit operands
//   result    : bits [SHIFT+DW-1:SHIFT] of the accumulator's next value,
//               so the caller can capture the final sum in the same edge
//               that adds the last product.
module zero_mac #(
  parameter int DW    = 32,
  parameter int ACCW  = 64,
  parameter int SHIFT = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic        [DW-1:0] result
);

  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_next;
  logic signed [ACCW-1:0] prod;

  // Operands are sign-extended to ACCW before the multiply so the full
  // signed product is formed; the sum wraps modulo 2**ACCW.
  assign prod = ACCW'(a) * ACCW'(b);

  always_comb begin
    acc_next = acc;
    if (clear) begin
      acc_next = '0;
    end else if (enable) begin
      acc_next = acc + prod;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end

  // Arithmetic shift then truncation: rounds toward negative infinity.
  assign result = acc_next[SHIFT+DW-1:SHIFT];

endmodule

// File: rtl/filtez_zero_predictor.sv
// Zero-section predictor (read side): ap_return = sum(bli[i]*dlti[i]) >>> SHIFT
// over NTAPS taps, under an ap_ctrl_hs block-level handshake.
// Ports:
//   ap_clk, ap_rst        : clock, asynchronous active-high reset
//   ap_start              : run request, sampled only in S_IDLE
//   ap_done, ap_ready     : one-cycle pulse in S_DONE; ap_return valid then
//   ap_idle               : high in S_IDLE
//   bli_address0/ce0/q0   : coefficient memory read port (1-cycle latency)
//   dlti_address0/ce0/q0  : delay-line memory read port (1-cycle latency)
//   ap_return             : registered signed result, held until next ap_done
//   dbg_state             : current FSM state, for observation only
// Handshake: a run is accepted when ap_start=1 in S_IDLE; ap_start is
// ignored at every other time. ap_done/ap_ready pulse together exactly once
// per run, NTAPS+2 cycles after acceptance; a reset aborts the run silently.
module filtez_zero_predictor
  import adpcm_pkg::*;
#(
  parameter int NTAPS = NTAPS_Z,
  parameter int AW    = 3,
  parameter int DW    = 32,
  parameter int ACCW  = 64,
  parameter int SHIFT = ZSHIFT
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          ap_start,
  output logic          ap_done,
  output logic          ap_idle,
  output logic          ap_ready,
  output logic [AW-1:0] bli_address0,
  output logic          bli_ce0,
  input  logic [DW-1:0] bli_q0,
  output logic [AW-1:0] dlti_address0,
  output logic          dlti_ce0,
  input  logic [DW-1:0] dlti_q0,
  output logic [DW-1:0] ap_return,
  output state_t        dbg_state
);

  state_t        state;
  logic [AW-1:0] idx;
  logic [AW-1:0] addr_q;    // last address issued; held outside S_FETCH
  logic          fetch_d;   // read data from the previous cycle is on q0
  logic          mac_clear;
  logic [DW-1:0] mac_result;

  wire is_fetch = (state == S_FETCH);
  wire last_tap = (idx == AW'(NTAPS - 1));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      addr_q    <= '0;
      fetch_d   <= 1'b0;
      ap_return <= '0;
    end else begin
      fetch_d <= is_fetch;
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            idx   <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          addr_q <= idx;
          idx    <= idx + AW'(1);
          if (last_tap) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The last product is added on this same edge, so capture the
          // MAC's next value rather than its current register.
          ap_return <= mac_result;
          state     <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign mac_clear = (state == S_IDLE) && ap_start;

  zero_mac #(
    .DW    (DW),
    .ACCW  (ACCW),
    .SHIFT (SHIFT)
  ) u_mac (
    .clk    (ap_clk),
    .rst    (ap_rst),
    .clear  (mac_clear),
    .enable (fetch_d),
    .a      (bli_q0),
    .b      (dlti_q0),
    .result (mac_result)
  );

  assign bli_ce0       = is_fetch;
  assign dlti_ce0      = is_fetch;
  assign bli_address0  = is_fetch ? idx : addr_q;
  assign dlti_address0 = is_fetch ? idx : addr_q;

  assign ap_idle   = (state == S_IDLE);
  assign ap_done   = (state == S_DONE);
  assign ap_ready  = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_filtez_zero_predictor.sv
module tb_filtez_zero_predictor;
  import adpcm_pkg::*;

  // ---------------- clock / reset ----------------
  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done, ap_idle, ap_ready;
  logic [2:0]  bli_address0, dlti_address0;
  logic        bli_ce0, dlti_ce0;
  logic [31:0] bli_q0, dlti_q0;
  logic [31:0] ap_return;
  state_t      dbg_state;

  always #5 ap_clk = ~ap_clk;

  filtez_zero_predictor dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .ap_ready      (ap_ready),
    .bli_address0  (bli_address0),
    .bli_ce0       (bli_ce0),
    .bli_q0        (bli_q0),
    .dlti_address0 (dlti_address0),
    .dlti_ce0      (dlti_ce0),
    .dlti_q0       (dlti_q0),
    .ap_return     (ap_return),
    .dbg_state     (dbg_state)
  );

  // ---------------- memory models ----------------
  logic [31:0] bli_mem  [8];
  logic [31:0] dlti_mem [8];
  int          rd_cnt   [8];

  initial begin
    bli_q0  = '0;
    dlti_q0 = '0;
    for (int i = 0; i < 8; i++) rd_cnt[i] = 0;
  end

  always @(posedge ap_clk) begin
    if (bli_ce0) begin
      bli_q0 <= bli_mem[bli_address0];
      rd_cnt[bli_address0] <= rd_cnt[bli_address0] + 1;
    end
    if (dlti_ce0) dlti_q0 <= dlti_mem[dlti_address0];
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  int snap [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 8; i++) begin
      bli_mem[i]  = '0;
      dlti_mem[i] = '0;
    end
  endtask

  task automatic snap_counts();
    for (int i = 0; i < 8; i++) snap[i] = rd_cnt[i];
  endtask

  task automatic check_counts(input string tag, input int per_addr);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s reads[%0d]", tag, i), 32'(rd_cnt[i] - snap[i]),
            (i < 6) ? 32'(per_addr) : 32'd0);
  endtask

  // Called at a negedge with the DUT idle; that negedge is cycle 0.
  task automatic run_one(input string tag, input logic [31:0] exp_ret);
    check($sformatf("%s idle c0", tag), 32'(ap_idle), 32'd1);
    ap_start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge ap_clk);
      if (c == 1) ap_start = 1'b0;
      check($sformatf("%s done c%0d", tag, c), 32'(ap_done), (c == 8) ? 32'd1 : 32'd0);
      check($sformatf("%s ready c%0d", tag, c), 32'(ap_ready), (c == 8) ? 32'd1 : 32'd0);
      check($sformatf("%s ce c%0d", tag, c), 32'({bli_ce0, dlti_ce0}),
            (c <= 6) ? 32'd3 : 32'd0);
      if (c <= 6) begin
        check($sformatf("%s bli addr c%0d", tag, c), 32'(bli_address0), 32'(c - 1));
        check($sformatf("%s dlti addr c%0d", tag, c), 32'(dlti_address0), 32'(c - 1));
      end
      if (c == 8) check($sformatf("%s ret at done", tag), ap_return, exp_ret);
    end
    check($sformatf("%s ret held", tag), ap_return, exp_ret);
    check($sformatf("%s idle end", tag), 32'(ap_idle), 32'd1);
  endtask

  task automatic load_basic();
    clear_mem();
    for (int i = 0; i < 6; i++) begin
      bli_mem[i]  = 32'd16384;
      dlti_mem[i] = 32'(i + 1);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    clear_mem();
    repeat (2) @(negedge ap_clk);

    // reset values
    check("rst idle", 32'(ap_idle), 32'd1);
    check("rst done", 32'(ap_done), 32'd0);
    check("rst ready", 32'(ap_ready), 32'd0);
    check("rst ce", 32'({bli_ce0, dlti_ce0}), 32'd0);
    check("rst addr", 32'({bli_address0, dlti_address0}), 32'd0);
    check("rst ret", ap_return, 32'd0);
    check("rst state", 32'(dbg_state), 32'(S_IDLE));
    ap_rst = 1'b0;
    @(negedge ap_clk);

    // 16384 * (1+2+...+6) >>> 14 = 21, every address read once
    load_basic();
    snap_counts();
    run_one("basic", 32'd21);
    check_counts("basic", 1);

    // -16384*3 >>> 14 = -3
    clear_mem();
    bli_mem[0] = -32'sd16384; dlti_mem[0] = 32'd3;
    run_one("neg", 32'hFFFF_FFFD);

    // 2**30 * 2**16 = 2**46: bits [45:14] are all zero
    clear_mem();
    bli_mem[0] = 32'h4000_0000; dlti_mem[0] = 32'h0001_0000;
    run_one("trunc", 32'h0000_0000);

    // -1 >>> 14 rounds toward -inf
    clear_mem();
    bli_mem[0] = 32'hFFFF_FFFF; dlti_mem[0] = 32'd1;
    run_one("round_neg", 32'hFFFF_FFFF);

    // 1 >>> 14 = 0
    clear_mem();
    bli_mem[0] = 32'd1; dlti_mem[0] = 32'd1;
    run_one("round_pos", 32'd0);

    // every tap contributes: 2*10 - 1*7 + 1*(-3) + 1*5 - 3*2 + 1*(-1) = 8
    clear_mem();
    bli_mem[0] = 32'd32768;     dlti_mem[0] = 32'd10;
    bli_mem[1] = -32'sd16384;   dlti_mem[1] = 32'd7;
    bli_mem[2] = 32'd16384;     dlti_mem[2] = -32'sd3;
    bli_mem[3] = 32'd16384;     dlti_mem[3] = 32'd5;
    bli_mem[4] = -32'sd49152;   dlti_mem[4] = 32'd2;
    bli_mem[5] = 32'd16384;     dlti_mem[5] = -32'sd1;
    run_one("mixed", 32'd8);

    // reset in cycle 4 of a run aborts it
    load_basic();
    ap_start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge ap_clk);
      if (c == 1) ap_start = 1'b0;
    end
    check("abort mid-run busy", 32'(ap_idle), 32'd0);
    ap_rst = 1'b1;
    #1;
    check("abort idle", 32'(ap_idle), 32'd1);
    check("abort ce", 32'({bli_ce0, dlti_ce0}), 32'd0);
    check("abort ret", ap_return, 32'd0);
    check("abort done", 32'(ap_done), 32'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge ap_clk);
      check($sformatf("abort no done %0d", c), 32'(ap_done), 32'd0);
    end
    run_one("after_abort", 32'd21);

    // start held high: two runs, done at 8 and 17; memory changes between runs
    load_basic();
    snap_counts();
    ap_start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge ap_clk);
      if (c == 9) begin
        for (int i = 0; i < 6; i++) dlti_mem[i] = 32'd2;
      end
      if (c == 12) ap_start = 1'b0;
      check($sformatf("b2b done c%0d", c), 32'(ap_done),
            (c == 8 || c == 17) ? 32'd1 : 32'd0);
      check($sformatf("b2b ce c%0d", c), 32'({bli_ce0, dlti_ce0}),
            ((c >= 1 && c <= 6) || (c >= 10 && c <= 15)) ? 32'd3 : 32'd0);
      if (c >= 1 && c <= 6)
        check($sformatf("b2b addr c%0d", c), 32'(bli_address0), 32'(c - 1));
      if (c >= 10 && c <= 15)
        check($sformatf("b2b addr c%0d", c), 32'(dlti_address0), 32'(c - 10));
      if (c == 8)  check("b2b ret1", ap_return, 32'd21);
      if (c == 17) check("b2b ret2", ap_return, 32'd12);
    end
    check_counts("b2b", 2);
    check("b2b idle end", 32'(ap_idle), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
